// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl
//   Show-ahead FIFO controller wrapped around an external single-cycle SRAM.
//   The SRAM's registered read data is the FIFO head stage. A prefetch issues
//   a read whenever the head is empty or is being consumed, so a pop never
//   leaves a bubble while the SRAM still holds entries.
//
// Ports
//   I_Clk, I_Rst_n          clock, async active-low reset
//   I_Flush                 synchronous clear (beats push/pop)
//   I_InValid/O_InReady/I_InData     push side
//   O_OutValid/I_OutReady/O_OutData  pop side (O_OutData = I_RdData)
//   O_Count, O_Empty, O_Full         occupancy status (SRAM + head stage)
//   O_WrEn/O_WrAddr/O_WrData         SRAM write port
//   O_RdEn/O_RdAddr, I_RdData        SRAM read port, registered read data
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 64,
  localparam int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic                  I_Clk,
  input  logic                  I_Rst_n,
  input  logic                  I_Flush,
  input  logic                  I_InValid,
  output logic                  O_InReady,
  input  logic [DATA_WIDTH-1:0] I_InData,
  output logic                  O_OutValid,
  input  logic                  I_OutReady,
  output logic [DATA_WIDTH-1:0] O_OutData,
  output logic [ADDR_WIDTH:0]   O_Count,
  output logic                  O_Empty,
  output logic                  O_Full,
  output logic                  O_WrEn,
  output logic [ADDR_WIDTH-1:0] O_WrAddr,
  output logic [DATA_WIDTH-1:0] O_WrData,
  output logic                  O_RdEn,
  output logic [ADDR_WIDTH-1:0] O_RdAddr,
  input  logic [DATA_WIDTH-1:0] I_RdData
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(RAM_DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_WIDTH:0] r_wptr;
  logic [ADDR_WIDTH:0] r_rptr;
  logic                r_out_valid;

  logic [ADDR_WIDTH:0] w_sram_cnt;
  logic                w_push;
  logic                w_pop;
  logic                w_prefetch;

  // Occupancy of the SRAM proper (excludes the head stage); natural rollover.
  assign w_sram_cnt = r_wptr - r_rptr;

  // Ready depends only on registered state, never on I_OutReady, so a pop
  // cannot open room for a push into a full SRAM in the same cycle.
  assign O_InReady  = (w_sram_cnt != DEPTH_C);
  assign w_push     = I_InValid && O_InReady && !I_Flush;
  assign w_pop      = r_out_valid && I_OutReady && !I_Flush;
  assign w_prefetch = (w_sram_cnt != '0) && (!r_out_valid || I_OutReady) && !I_Flush;

  assign O_WrEn   = w_push;
  assign O_WrAddr = r_wptr[ADDR_WIDTH-1:0];
  assign O_WrData = I_InData;
  assign O_RdEn   = w_prefetch;
  assign O_RdAddr = r_rptr[ADDR_WIDTH-1:0];

  assign O_OutValid = r_out_valid;
  assign O_OutData  = I_RdData;
  assign O_Count    = w_sram_cnt + {{ADDR_WIDTH{1'b0}}, r_out_valid};
  assign O_Empty    = (O_Count == '0);
  assign O_Full     = !O_InReady;

  always_ff @(posedge I_Clk or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_out_valid <= 1'b0;
    end else if (I_Flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push)     r_wptr <= r_wptr + 1'b1;
      if (w_prefetch) r_rptr <= r_rptr + 1'b1;
      // A prefetch refills the head; a pop without refill drains it.
      if (w_prefetch)  r_out_valid <= 1'b1;
      else if (w_pop)  r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl
//   Bench for sram_fifo_ctrl with DATA_WIDTH=8, RAM_DEPTH=4 and a behavioural
//   SRAM (registered read, holds while not read). Directed vector table,
//   streaming and async-reset sequences, then randomized traffic checked
//   against a queue-based model of the SRAM contents plus a head register.
module tb_sram_fifo_ctrl;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW:0]   count;
  logic          empty, full;
  logic          wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data = '0;

  logic [DW-1:0] mem [DEPTH];

  int n_tot = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sram_fifo_ctrl #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH)) dut (
    .I_Clk(clk), .I_Rst_n(rst_n), .I_Flush(flush),
    .I_InValid(in_valid), .O_InReady(in_ready), .I_InData(in_data),
    .O_OutValid(out_valid), .I_OutReady(out_ready), .O_OutData(out_data),
    .O_Count(count), .O_Empty(empty), .O_Full(full),
    .O_WrEn(wr_en), .O_WrAddr(wr_addr), .O_WrData(wr_data),
    .O_RdEn(rd_en), .O_RdAddr(rd_addr), .I_RdData(rd_data)
  );

  // Behavioural SRAM: registered read port, output holds while not read.
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] din;
    logic          ordy;
    logic          fl;
    logic          e_wren;
    logic          e_rden;
    logic          e_inrdy;
    logic          e_valid;
    logic [AW:0]   e_cnt;
    logic          e_chkd;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic iv, logic [DW-1:0] din, logic ordy, logic fl,
                              logic wren, logic rden, logic inrdy, logic valid,
                              logic [AW:0] cnt, logic chkd, logic [DW-1:0] dat);
    vec_t v;
    v.iv = iv; v.din = din; v.ordy = ordy; v.fl = fl;
    v.e_wren = wren; v.e_rden = rden; v.e_inrdy = inrdy; v.e_valid = valid;
    v.e_cnt = cnt; v.e_chkd = chkd; v.e_data = dat;
    return v;
  endfunction

  // Reference model: SRAM contents as a queue plus a head register.
  logic [DW-1:0] mq[$];
  logic          m_hv;
  logic [DW-1:0] m_hd;

  int sent, recv, gaps, acc;

  initial begin
    // iv din ordy fl | wren rden inrdy valid cnt chkd data
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00)); // idle after reset
    vt.push_back(mk(1, 8'hA1, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00)); // push A1 at t0
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 0, 1, 0, 8'h00)); // t1: read issued
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 1, 1, 1, 8'hA1)); // t2: head valid
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 1, 1, 1, 8'hA1)); // pop it
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00)); // empty again
    vt.push_back(mk(1, 8'h01, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00));
    vt.push_back(mk(1, 8'h02, 0, 0, 1, 1, 1, 0, 1, 0, 8'h00));
    vt.push_back(mk(1, 8'h03, 0, 0, 1, 0, 1, 1, 2, 1, 8'h01));
    vt.push_back(mk(1, 8'h04, 0, 0, 1, 0, 1, 1, 3, 1, 8'h01));
    vt.push_back(mk(1, 8'h05, 0, 0, 1, 0, 1, 1, 4, 1, 8'h01));
    vt.push_back(mk(1, 8'h06, 0, 0, 0, 0, 0, 1, 5, 1, 8'h01)); // full, sixth refused
    vt.push_back(mk(1, 8'h07, 1, 1, 0, 0, 0, 1, 5, 1, 8'h01)); // flush beats push+pop
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00)); // cleared

    // Reset held: outputs must already show the cleared state.
    #12;
    chk("rst_inready", in_ready, 1); chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);        chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);  chk("rst_rden", rd_en, 0);
    chk("rst_wren", wr_en, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    foreach (vt[i]) begin
      in_valid = vt[i].iv; in_data = vt[i].din; out_ready = vt[i].ordy; flush = vt[i].fl;
      @(negedge clk);
      chk($sformatf("v%0d_wren", i), wr_en, vt[i].e_wren);
      chk($sformatf("v%0d_rden", i), rd_en, vt[i].e_rden);
      chk($sformatf("v%0d_inrdy", i), in_ready, vt[i].e_inrdy);
      chk($sformatf("v%0d_full", i), full, !vt[i].e_inrdy);
      chk($sformatf("v%0d_valid", i), out_valid, vt[i].e_valid);
      chk($sformatf("v%0d_count", i), count, vt[i].e_cnt);
      chk($sformatf("v%0d_empty", i), empty, vt[i].e_cnt == 0);
      if (vt[i].e_chkd) chk($sformatf("v%0d_data", i), out_data, vt[i].e_data);
      if (vt[i].e_wren) chk($sformatf("v%0d_wdata", i), wr_data, vt[i].din);
      @(posedge clk); #1;
    end
    in_valid = 0; flush = 0;

    // Streaming 0..9 through a depth-4 SRAM: wraps pointers, no gaps.
    sent = 0; recv = 0; gaps = 0; out_ready = 1;
    for (int c = 0; c < 40 && recv < 10; c++) begin
      in_valid = (sent < 10); in_data = DW'(sent);
      @(negedge clk);
      acc = wr_en;
      if (out_valid) begin
        chk($sformatf("stream_%0d", recv), out_data, recv);
        recv++;
      end else if (recv > 0) gaps++;
      @(posedge clk); #1;
      if (acc != 0) sent++;
    end
    in_valid = 0; out_ready = 0;
    chk("stream_received", recv, 10);
    chk("stream_gaps", gaps, 0);
    @(posedge clk); #1;

    // Async reset with three entries held.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_data = DW'(8'h30 + k);
      @(posedge clk); #1;
    end
    in_valid = 0;
    @(negedge clk);
    chk("pre_rst_count", count, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);    chk("arst_empty", empty, 1);
    chk("arst_full", full, 0);      chk("arst_inready", in_ready, 1);
    chk("arst_valid", out_valid, 0); chk("arst_rden", rd_en, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Randomized traffic against the queue model.
    mq.delete(); m_hv = 0; m_hd = '0;
    for (int c = 0; c < 600; c++) begin
      int seg;
      logic e_inrdy, e_push, e_pop, e_pref;
      seg = (c / 100) % 3;
      in_valid  = (seg == 1) ? ($urandom_range(9) < 8) : ($urandom_range(1) == 1);
      out_ready = (seg == 1) ? ($urandom_range(9) < 2) :
                  (seg == 2) ? ($urandom_range(9) < 8) : ($urandom_range(1) == 1);
      flush     = ($urandom_range(49) == 0);
      in_data   = DW'($urandom);
      @(negedge clk);
      e_inrdy = (mq.size() != DEPTH);
      e_push  = in_valid && e_inrdy && !flush;
      e_pop   = m_hv && out_ready && !flush;
      e_pref  = (mq.size() != 0) && (!m_hv || out_ready) && !flush;
      chk("rnd_inready", in_ready, e_inrdy);
      chk("rnd_wren", wr_en, e_push);
      chk("rnd_rden", rd_en, e_pref);
      chk("rnd_valid", out_valid, m_hv);
      chk("rnd_count", count, mq.size() + int'(m_hv));
      chk("rnd_empty", empty, (mq.size() == 0) && !m_hv);
      chk("rnd_full", full, !e_inrdy);
      if (m_hv) chk("rnd_data", out_data, m_hd);
      if (flush) begin
        mq.delete(); m_hv = 0;
      end else begin
        if (e_pref) begin m_hd = mq.pop_front(); m_hv = 1; end
        else if (e_pop) m_hv = 0;
        if (e_push) mq.push_back(in_data);
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
